// File: rtl/colour_centroid_tracker.sv
// colour_centroid_tracker
//   Streaming colour-blob tracker. Each valid pixel is classified against the
//   target channel and, if it is a hit inside the frame, it is added to the
//   per-frame count / sum_x / sum_y. At end of frame a single sequential
//   restoring divider produces centroid_x, centroid_y and the FOV heading in turn.
//
//   Optional feature macro: BBOX_EN adds a per-frame bounding box of hit pixels.
//
// Ports
//   clk, rst       clock, asynchronous active-high reset
//   pix_valid      pixel beat valid (no backpressure)
//   pix_sof        beat is pixel (0,0) of a new frame
//   pix_eof        beat is the last pixel of the frame
//   pix_data       {R,G,B}, CH_BITS each
//   hit            previous beat classified as target
//   result_valid   one-cycle pulse when the result outputs update
//   centroid_x/y   floor(sum/count)
//   heading        floor(FOV*centroid_x/(IMAGE_WIDTH-1))
//   pixel_count    hits in last completed frame
//   no_target      pixel_count < MIN_PIXELS
//   busy           divider FSM not idle
//   overrun        sticky: eof arrived while a result was still being computed
//   bbox_*         (BBOX_EN only) min/max of hit coordinates
module colour_centroid_tracker #(
  parameter int IMAGE_WIDTH  = 320,
  parameter int IMAGE_HEIGHT = 240,
  parameter int CH_BITS      = 4,
  parameter int TARGET_CH    = 0,
  parameter int THRESHOLD    = 3,
  parameter int MIN_PIXELS   = 500,
  parameter int FOV          = 25,
  localparam int X_W   = $clog2(IMAGE_WIDTH),
  localparam int Y_W   = $clog2(IMAGE_HEIGHT),
  localparam int CNT_W = $clog2(IMAGE_WIDTH*IMAGE_HEIGHT+1),
  localparam int SUM_W = CNT_W + X_W,
  localparam int H_W   = $clog2(FOV+1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pix_valid,
  input  logic                 pix_sof,
  input  logic                 pix_eof,
  input  logic [3*CH_BITS-1:0] pix_data,
  output logic                 hit,
  output logic                 result_valid,
  output logic [X_W-1:0]       centroid_x,
  output logic [Y_W-1:0]       centroid_y,
  output logic [H_W-1:0]       heading,
  output logic [CNT_W-1:0]     pixel_count,
  output logic                 no_target,
  output logic                 busy,
  output logic                 overrun
`ifdef BBOX_EN
  ,
  output logic [X_W-1:0]       bbox_xmin,
  output logic [X_W-1:0]       bbox_xmax,
  output logic [Y_W-1:0]       bbox_ymin,
  output logic [Y_W-1:0]       bbox_ymax
`endif
);

  localparam int BC_W = $clog2(SUM_W);
  localparam logic [BC_W-1:0]    LAST_BIT = BC_W'(SUM_W-1);
  localparam logic [CH_BITS:0]   THR_V    = (CH_BITS+1)'(THRESHOLD);
  localparam logic [X_W-1:0]     XMAX_V   = X_W'(IMAGE_WIDTH-1);
  localparam logic [Y_W:0]       YLIM_V   = (Y_W+1)'(IMAGE_HEIGHT);
  localparam logic [CNT_W-1:0]   MIN_V    = CNT_W'(MIN_PIXELS);
  localparam logic [SUM_W-1:0]   FOV_V    = SUM_W'(FOV);
  localparam logic [SUM_W-1:0]   WM1_V    = SUM_W'(IMAGE_WIDTH-1);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_DIV_X, S_DIV_Y, S_DIV_H, S_DONE} state_t;
  state_t state;

  // ---------------- classification ----------------
  logic [CH_BITS:0] ch_r, ch_g, ch_b, t_lvl, o1_lvl, o2_lvl;
  logic             is_target;

  always_comb begin
    ch_r   = {1'b0, pix_data[3*CH_BITS-1 -: CH_BITS]};
    ch_g   = {1'b0, pix_data[2*CH_BITS-1 -: CH_BITS]};
    ch_b   = {1'b0, pix_data[CH_BITS-1:0]};
    t_lvl  = ch_r;
    o1_lvl = ch_g;
    o2_lvl = ch_b;
    case (TARGET_CH)
      1: begin t_lvl = ch_g; o1_lvl = ch_r; o2_lvl = ch_b; end
      2: begin t_lvl = ch_b; o1_lvl = ch_r; o2_lvl = ch_g; end
      default: ;
    endcase
    is_target = (t_lvl > THR_V) && (o1_lvl + THR_V < t_lvl) && (o2_lvl + THR_V < t_lvl);
  end

  // ---------------- pixel path / accumulators ----------------
  logic [X_W-1:0]   x_pos;
  logic [Y_W:0]     y_pos;     // one extra bit so it can park at IMAGE_HEIGHT
  logic [CNT_W-1:0] acc_cnt, cnt_nxt;
  logic [SUM_W-1:0] acc_sx, acc_sy, sx_nxt, sy_nxt;
  logic             clear_pend, start_pend;
  logic [X_W-1:0]   beat_x;
  logic [Y_W:0]     beat_y;
  logic             in_range, add, clr, accept;
`ifdef BBOX_EN
  logic [X_W-1:0]   acc_xmin, acc_xmax, xmin_nxt, xmax_nxt;
  logic [Y_W-1:0]   acc_ymin, acc_ymax, ymin_nxt, ymax_nxt;
`endif

  always_comb begin
    beat_x   = pix_sof ? '0 : x_pos;
    beat_y   = pix_sof ? '0 : y_pos;
    in_range = beat_y < YLIM_V;
    add      = pix_valid & is_target & in_range;
    // clear_pend: the cycle after eof, whether or not the frame was accepted
    clr      = clear_pend | (pix_valid & pix_sof);
    accept   = pix_valid & pix_eof & (state == S_IDLE) & ~start_pend;
    cnt_nxt  = clr ? '0 : acc_cnt;
    sx_nxt   = clr ? '0 : acc_sx;
    sy_nxt   = clr ? '0 : acc_sy;
    if (add) begin
      cnt_nxt = cnt_nxt + CNT_W'(1);
      sx_nxt  = sx_nxt + SUM_W'(beat_x);
      sy_nxt  = sy_nxt + SUM_W'(beat_y);
    end
`ifdef BBOX_EN
    xmin_nxt = clr ? '1 : acc_xmin;
    xmax_nxt = clr ? '0 : acc_xmax;
    ymin_nxt = clr ? '1 : acc_ymin;
    ymax_nxt = clr ? '0 : acc_ymax;
    if (add) begin
      if (beat_x < xmin_nxt)          xmin_nxt = beat_x;
      if (beat_x > xmax_nxt)          xmax_nxt = beat_x;
      if (beat_y[Y_W-1:0] < ymin_nxt) ymin_nxt = beat_y[Y_W-1:0];
      if (beat_y[Y_W-1:0] > ymax_nxt) ymax_nxt = beat_y[Y_W-1:0];
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit        <= 1'b0;
      overrun    <= 1'b0;
      clear_pend <= 1'b0;
      start_pend <= 1'b0;
      x_pos      <= '0;
      y_pos      <= '0;
      acc_cnt    <= '0;
      acc_sx     <= '0;
      acc_sy     <= '0;
`ifdef BBOX_EN
      acc_xmin   <= '1;
      acc_xmax   <= '0;
      acc_ymin   <= '1;
      acc_ymax   <= '0;
`endif
    end else begin
      hit        <= pix_valid & is_target;
      clear_pend <= pix_valid & pix_eof;
      start_pend <= accept;
      if (pix_valid & pix_eof & ~accept)
        overrun <= 1'b1;
      if (pix_valid) begin
        if (beat_x == XMAX_V) begin
          x_pos <= '0;
          y_pos <= (beat_y == YLIM_V) ? beat_y : beat_y + (Y_W+1)'(1);
        end else begin
          x_pos <= beat_x + X_W'(1);
          y_pos <= beat_y;
        end
      end
      acc_cnt <= cnt_nxt;
      acc_sx  <= sx_nxt;
      acc_sy  <= sy_nxt;
`ifdef BBOX_EN
      acc_xmin <= xmin_nxt;
      acc_xmax <= xmax_nxt;
      acc_ymin <= ymin_nxt;
      acc_ymax <= ymax_nxt;
`endif
    end
  end

  // ---------------- shared restoring divider + FSM ----------------
  logic [CNT_W-1:0] cnt_op;
  logic [SUM_W-1:0] sx_op, sy_op;
  logic [SUM_W-1:0] quo, rem, dvs;
  logic [BC_W-1:0]  bit_cnt;
  logic             nt_q;
  logic [X_W-1:0]   cx_q;
  logic [Y_W-1:0]   cy_q;
  logic [SUM_W:0]   rem_sh, diff;
  logic             q_bit;
  logic [SUM_W-1:0] q_next, rem_next;
`ifdef BBOX_EN
  logic [X_W-1:0]   bxmin_op, bxmax_op;
  logic [Y_W-1:0]   bymin_op, bymax_op;
`endif

  // quo holds the remaining dividend bits in its top and collects quotient
  // bits in its bottom; after SUM_W steps it is the full quotient.
  always_comb begin
    rem_sh   = {rem, quo[SUM_W-1]};
    diff     = rem_sh - {1'b0, dvs};
    q_bit    = ~diff[SUM_W];
    rem_next = q_bit ? diff[SUM_W-1:0] : rem_sh[SUM_W-1:0];
    q_next   = {quo[SUM_W-2:0], q_bit};
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      result_valid <= 1'b0;
      centroid_x   <= '0;
      centroid_y   <= '0;
      heading      <= '0;
      pixel_count  <= '0;
      no_target    <= 1'b0;
      cnt_op       <= '0;
      sx_op        <= '0;
      sy_op        <= '0;
      quo          <= '0;
      rem          <= '0;
      dvs          <= '0;
      bit_cnt      <= '0;
      nt_q         <= 1'b0;
      cx_q         <= '0;
      cy_q         <= '0;
`ifdef BBOX_EN
      bbox_xmin    <= '0;
      bbox_xmax    <= '0;
      bbox_ymin    <= '0;
      bbox_ymax    <= '0;
      bxmin_op     <= '0;
      bxmax_op     <= '0;
      bymin_op     <= '0;
      bymax_op     <= '0;
`endif
    end else begin
      result_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_pend) begin
            cnt_op <= acc_cnt;
            sx_op  <= acc_sx;
            sy_op  <= acc_sy;
`ifdef BBOX_EN
            bxmin_op <= acc_xmin;
            bxmax_op <= acc_xmax;
            bymin_op <= acc_ymin;
            bymax_op <= acc_ymax;
`endif
            state  <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (cnt_op < MIN_V || cnt_op == '0) begin
            nt_q  <= 1'b1;
            state <= S_DONE;
          end else begin
            nt_q    <= 1'b0;
            quo     <= sx_op;
            rem     <= '0;
            dvs     <= {{(SUM_W-CNT_W){1'b0}}, cnt_op};
            bit_cnt <= '0;
            state   <= S_DIV_X;
          end
        end
        S_DIV_X, S_DIV_Y, S_DIV_H: begin
          quo     <= q_next;
          rem     <= rem_next;
          bit_cnt <= bit_cnt + BC_W'(1);
          if (bit_cnt == LAST_BIT) begin
            rem     <= '0;
            bit_cnt <= '0;
            if (state == S_DIV_X) begin
              cx_q  <= q_next[X_W-1:0];
              quo   <= sy_op;
              state <= S_DIV_Y;
            end else if (state == S_DIV_Y) begin
              cy_q  <= q_next[Y_W-1:0];
              quo   <= FOV_V * {{(SUM_W-X_W){1'b0}}, cx_q};
              dvs   <= WM1_V;
              state <= S_DIV_H;
            end else begin
              state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          result_valid <= 1'b1;
          pixel_count  <= cnt_op;
          no_target    <= nt_q;
          if (!nt_q) begin
            centroid_x <= cx_q;
            centroid_y <= cy_q;
            heading    <= quo[H_W-1:0];
          end
`ifdef BBOX_EN
          bbox_xmin <= nt_q ? '1 : bxmin_op;
          bbox_xmax <= nt_q ? '0 : bxmax_op;
          bbox_ymin <= nt_q ? '1 : bymin_op;
          bbox_ymax <= nt_q ? '0 : bymax_op;
`endif
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_colour_centroid_tracker.sv
module tb_colour_centroid_tracker;

  localparam int X_W = 9, Y_W = 8, CNT_W = 17, H_W = 5;

  logic        clk, rst;
  logic        pix_valid, pix_sof, pix_eof;
  logic [11:0] pix_data;

  logic             r_hit, r_rv, r_nt, r_busy, r_ovr;
  logic [X_W-1:0]   r_cx;
  logic [Y_W-1:0]   r_cy;
  logic [H_W-1:0]   r_h;
  logic [CNT_W-1:0] r_cnt;
  logic             g_hit, g_rv, g_nt, g_busy, g_ovr;
  logic [X_W-1:0]   g_cx;
  logic [Y_W-1:0]   g_cy;
  logic [H_W-1:0]   g_h;
  logic [CNT_W-1:0] g_cnt;
`ifdef BBOX_EN
  logic [X_W-1:0] r_bxmin, r_bxmax, g_bxmin, g_bxmax;
  logic [Y_W-1:0] r_bymin, r_bymax, g_bymin, g_bymax;
`endif

  int total = 0;
  int bad   = 0;

  // red-target tracker with default geometry
  colour_centroid_tracker #(.TARGET_CH(0), .MIN_PIXELS(500)) u_r (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_sof(pix_sof), .pix_eof(pix_eof),
    .pix_data(pix_data), .hit(r_hit), .result_valid(r_rv), .centroid_x(r_cx),
    .centroid_y(r_cy), .heading(r_h), .pixel_count(r_cnt), .no_target(r_nt),
    .busy(r_busy), .overrun(r_ovr)
`ifdef BBOX_EN
    , .bbox_xmin(r_bxmin), .bbox_xmax(r_bxmax), .bbox_ymin(r_bymin), .bbox_ymax(r_bymax)
`endif
  );

  // green-target tracker with a small hit threshold, sharing the same stream
  colour_centroid_tracker #(.TARGET_CH(1), .MIN_PIXELS(4)) u_g (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_sof(pix_sof), .pix_eof(pix_eof),
    .pix_data(pix_data), .hit(g_hit), .result_valid(g_rv), .centroid_x(g_cx),
    .centroid_y(g_cy), .heading(g_h), .pixel_count(g_cnt), .no_target(g_nt),
    .busy(g_busy), .overrun(g_ovr)
`ifdef BBOX_EN
    , .bbox_xmin(g_bxmin), .bbox_xmax(g_bxmax), .bbox_ymin(g_bymin), .bbox_ymax(g_bymax)
`endif
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic send(input logic sof, input logic eof, input logic [11:0] d);
    pix_valid = 1'b1;
    pix_sof   = sof;
    pix_eof   = eof;
    pix_data  = d;
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    pix_eof   = 1'b0;
    pix_data  = '0;
  endtask

  // 0: black, 1: red block x100..109 y50..99, 2: all red, 3: green at x=319
  function automatic logic [11:0] pix_at(input int mode, input int x, input int y);
    case (mode)
      1: return (x >= 100 && x <= 109 && y >= 50 && y <= 99) ? 12'hF00 : 12'h000;
      2: return 12'hF00;
      3: return (x == 319) ? 12'h0F0 : 12'h000;
      default: return 12'h000;
    endcase
  endfunction

  task automatic run_frame(input int mode, input int n, input bit do_eof);
    for (int i = 0; i < n; i++)
      send(i == 0, do_eof && (i == n-1), pix_at(mode, i % 320, i / 320));
  endtask

  // cycles from the eof edge until result_valid is seen; -1 on timeout
  task automatic wait_rv(input int which, output int lat);
    lat = -1;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk);
      #1;
      if ((which == 0) ? r_rv : g_rv) begin
        lat = n;
        break;
      end
    end
  endtask

  typedef struct {
    logic [11:0] d;
    logic        exp_r;
    logic        exp_g;
  } cls_vec_t;

  cls_vec_t vecs[13];

  initial begin
    int lat, pulses, first_lat;
    logic [X_W-1:0] cap_cx;
    logic [Y_W-1:0] cap_cy;
    logic [H_W-1:0] cap_h;
    logic [CNT_W-1:0] cap_cnt;
    logic cap_nt;

    vecs[0]  = '{12'h400, 1'b1, 1'b0};
    vecs[1]  = '{12'h300, 1'b0, 1'b0};
    vecs[2]  = '{12'h740, 1'b0, 1'b0};
    vecs[3]  = '{12'h840, 1'b1, 1'b0};
    vecs[4]  = '{12'h750, 1'b0, 1'b0};
    vecs[5]  = '{12'h0F0, 1'b0, 1'b1};
    vecs[6]  = '{12'hF00, 1'b1, 1'b0};
    vecs[7]  = '{12'h0F8, 1'b0, 1'b1};
    vecs[8]  = '{12'h0FC, 1'b0, 1'b0};
    vecs[9]  = '{12'h000, 1'b0, 1'b0};
    vecs[10] = '{12'hFFF, 1'b0, 1'b0};
    vecs[11] = '{12'h040, 1'b0, 1'b1};
    vecs[12] = '{12'h730, 1'b1, 1'b0};

    rst = 1'b1;
    pix_valid = 1'b0; pix_sof = 1'b0; pix_eof = 1'b0; pix_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    check("rst_hit", r_hit, 0);
    check("rst_rv", r_rv, 0);
    check("rst_cx", r_cx, 0);
    check("rst_cy", r_cy, 0);
    check("rst_heading", r_h, 0);
    check("rst_count", r_cnt, 0);
    check("rst_no_target", r_nt, 0);
    check("rst_busy", r_busy, 0);
    check("rst_overrun", r_ovr, 0);

    // classification table
    for (int i = 0; i < 13; i++) begin
      send(1'b0, 1'b0, vecs[i].d);
      check($sformatf("hit_r[%0d]", i), r_hit, vecs[i].exp_r);
      check($sformatf("hit_g[%0d]", i), g_hit, vecs[i].exp_g);
    end

    // 10x50 red block: 500 hits
    run_frame(1, 99*320 + 110, 1'b1);
    wait_rv(0, lat);
    check("t1_latency", lat, 81);
    check("t1_count", r_cnt, 500);
    check("t1_no_target", r_nt, 0);
    check("t1_cx", r_cx, 104);
    check("t1_cy", r_cy, 74);
    check("t1_heading", r_h, 8);
`ifdef BBOX_EN
    check("t1_bxmin", r_bxmin, 100);
    check("t1_bxmax", r_bxmax, 109);
    check("t1_bymin", r_bymin, 50);
    check("t1_bymax", r_bymax, 99);
`endif

    // 499 hits: below MIN_PIXELS, centroid holds
    run_frame(2, 499, 1'b1);
    wait_rv(0, lat);
    check("t2_latency", lat, 3);
    check("t2_count", r_cnt, 499);
    check("t2_no_target", r_nt, 1);
    check("t2_cx_hold", r_cx, 104);
    check("t2_cy_hold", r_cy, 74);
    check("t2_heading_hold", r_h, 8);
`ifdef BBOX_EN
    check("t2_bxmin", r_bxmin, 511);
    check("t2_bxmax", r_bxmax, 0);
    check("t2_bymin", r_bymin, 255);
    check("t2_bymax", r_bymax, 0);
`endif

    // sof and eof on one beat
    send(1'b1, 1'b1, 12'hF00);
    wait_rv(0, lat);
    check("onepix_latency", lat, 3);
    check("onepix_count", r_cnt, 1);
    check("onepix_no_target", r_nt, 1);

    // green column at x=319, rows 0..4 -> heading at full FOV
    run_frame(3, 5*320, 1'b1);
    wait_rv(1, lat);
    check("grn_latency", lat, 81);
    check("grn_count", g_cnt, 5);
    check("grn_no_target", g_nt, 0);
    check("grn_cx", g_cx, 319);
    check("grn_cy", g_cy, 2);
    check("grn_heading", g_h, 25);
    check("grn_red_count", r_cnt, 0);
    check("grn_red_no_target", r_nt, 1);
    check("pre_overrun", r_ovr, 0);

    // partial frame discarded by a new sof, then a second eof while dividing
    run_frame(2, 300, 1'b0);
    run_frame(2, 600, 1'b1);
    run_frame(0, 20, 1'b1);
    pulses = 0; first_lat = -1;
    cap_cx = '0; cap_cy = '0; cap_h = '0; cap_cnt = '0; cap_nt = 1'b1;
    for (int n = 1; n <= 120; n++) begin
      @(posedge clk);
      #1;
      if (r_rv) begin
        if (pulses == 0) begin
          first_lat = n + 20;
          cap_cx = r_cx; cap_cy = r_cy; cap_h = r_h; cap_cnt = r_cnt; cap_nt = r_nt;
        end
        pulses++;
      end
    end
    check("t5_pulses", pulses, 1);
    check("t5_latency", first_lat, 81);
    check("t5_count", cap_cnt, 600);
    check("t5_no_target", cap_nt, 0);
    check("t5_cx", cap_cx, 150);
    check("t5_cy", cap_cy, 0);
    check("t5_heading", cap_h, 11);
    check("t4_overrun", r_ovr, 1);
    check("t4_idle_after", r_busy, 0);

    // reset during DIV_Y
    run_frame(2, 500, 1'b1);
    repeat (40) @(posedge clk);
    #2;
    check("t6_busy_before", r_busy, 1);
    rst = 1'b1;
    #1;
    check("t6_busy", r_busy, 0);
    check("t6_rv", r_rv, 0);
    check("t6_overrun", r_ovr, 0);
    check("t6_count", r_cnt, 0);
    check("t6_cx", r_cx, 0);
    check("t6_cy", r_cy, 0);
    check("t6_heading", r_h, 0);
    check("t6_no_target", r_nt, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    pulses = 0;
    for (int n = 0; n < 100; n++) begin
      @(posedge clk);
      #1;
      if (r_rv) pulses++;
    end
    check("t6_no_result", pulses, 0);
    check("t6_busy_after", r_busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
